// File: rtl/rggen_rr_arbiter_mux.sv
// Round-robin arbiter with a registered one-hot grant and an AND-OR payload mux
// that shares one valid/ready downstream channel among REQUESTERS sources.
module rggen_rr_arbiter_mux #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [REQUESTERS-1:0]       i_request,
  input  logic [REQUESTERS*WIDTH-1:0] i_data,
  output logic [REQUESTERS-1:0]       o_grant,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WIDTH-1:0]            o_data,
  output logic [REQUESTERS-1:0]       o_ack
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(REQUESTERS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [REQUESTERS-1:0]   candidates;

  // First set candidate scanning upward from the slot after the last served one.
  function automatic logic [REQUESTERS-1:0] pick_winner(
    input logic [REQUESTERS-1:0] cand,
    input logic [IDX_W-1:0]      last
  );
    logic [REQUESTERS-1:0] win;
    logic                  found;
    logic [IDX_W-1:0]      idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      idx = IDX_W'((int'(last) + k) % REQUESTERS);
      if (!found && cand[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_index(input logic [REQUESTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // The source just accepted is masked out, so a re-requester waits behind others.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    candidates = '0;
    case (state_q)
      IDLE: begin
        if (i_request != '0) begin
          grant_d = pick_winner(i_request, last_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_ready) begin
          last_d     = onehot_index(grant_q);
          candidates = i_request & ~grant_q;
          if (candidates != '0) begin
            grant_d = pick_winner(candidates, onehot_index(grant_q));
            state_d = BUSY;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    o_grant = grant_q;
    o_valid = (state_q == BUSY);
    o_ack   = grant_q & {REQUESTERS{(state_q == BUSY) & i_ready}};
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      o_data = o_data | ({WIDTH{grant_q[i]}} & i_data[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: tb/tb_rggen_rr_arbiter_mux.sv
// Directed-vector bench for rggen_rr_arbiter_mux: a 4-source/32-bit instance and
// a single-source/8-bit instance, with hand-computed expectations per cycle.
module tb_rggen_rr_arbiter_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic         ready;
  logic [3:0]   grant;
  logic         valid;
  logic [31:0]  odata;
  logic [3:0]   ack;

  logic [0:0]   req1;
  logic [7:0]   data1;
  logic [0:0]   grant1;
  logic         valid1;
  logic [7:0]   odata1;
  logic [0:0]   ack1;

  int evaluated = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  rggen_rr_arbiter_mux #(.REQUESTERS(4), .WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_request(req), .i_data(data),
    .o_grant(grant), .o_valid(valid), .i_ready(ready), .o_data(odata), .o_ack(ack)
  );

  rggen_rr_arbiter_mux #(.REQUESTERS(1), .WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_request(req1), .i_data(data1),
    .o_grant(grant1), .o_valid(valid1), .i_ready(ready), .o_data(odata1), .o_ack(ack1)
  );

  // A granted source must keep requesting until its acknowledge.
  assert property (@(posedge clk) disable iff (rst) valid |-> |(req & grant))
    else $error("[TB] request withdrawn while granted");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    req1  = '0;
    data  = '0;
    data1 = '0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = '0;
    req1  = '0;
    data  = '0;
    data1 = '0;
    ready = 1'b0;
    tick();
    tick();
    evaluated++;
    if ({grant, valid, ack, odata} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {grant, valid, ack, odata});
    end
    evaluated++;
    if ({grant1, valid1, ack1, odata1} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_n1: got %h expected 0", {grant1, valid1, ack1, odata1});
    end
    rst = 1'b0;
    tick();
    evaluated++;
    if ({grant, valid} !== 5'd0) begin
      failures++;
      $display("[TB] FAIL idle_no_request: got %h expected 0", {grant, valid});
    end
  endtask

  task automatic test_single();
    do_reset();
    req   = 4'b0100;
    data[2*32 +: 32] = 32'hA5A5_0002;
    ready = 1'b1;
    #1;
    evaluated++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_latency: valid got %b expected 0", valid);
    end
    tick();
    evaluated++;
    if ({grant, valid, ack, odata} !== {4'b0100, 1'b1, 4'b0100, 32'hA5A5_0002}) begin
      failures++;
      $display("[TB] FAIL single_grant: got %h expected %h", {grant, valid, ack, odata},
               {4'b0100, 1'b1, 4'b0100, 32'hA5A5_0002});
    end
    tick();
    req = 4'b0000;
    #1;
    evaluated++;
    if ({grant, valid, ack, odata} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL single_idle: got %h expected 0", {grant, valid, ack, odata});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'hC0DE_0000 | i;
    req   = 4'b1111;
    ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      evaluated++;
      if ({grant, valid, ack} !== {exp_g, 1'b1, exp_g}) begin
        failures++;
        $display("[TB] FAIL rr_cycle%0d: got grant=%b valid=%b ack=%b expected grant=%b valid=1 ack=%b",
                 k, grant, valid, ack, exp_g, exp_g);
      end
      evaluated++;
      if (odata !== (32'hC0DE_0000 | (k % 4))) begin
        failures++;
        $display("[TB] FAIL rr_data%0d: got %h expected %h", k, odata, 32'hC0DE_0000 | (k % 4));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req   = 4'b0011;
    ready = 1'b0;
    tick();
    for (int c = 1; c <= 6; c++) begin
      ready = (c == 6);
      #1;
      evaluated++;
      if ({grant, valid, ack} !== {4'b0001, 1'b1, (c == 6) ? 4'b0001 : 4'b0000}) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: got grant=%b valid=%b ack=%b", c, grant, valid, ack);
      end
      if (c < 6) tick();
    end
    tick();
    req = 4'b0010;
    #1;
    evaluated++;
    if ({grant, ack} !== {4'b0010, 4'b0010}) begin
      failures++;
      $display("[TB] FAIL hold_next: got grant=%b ack=%b expected grant=0010 ack=0010", grant, ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    do_reset();
    req   = 4'b1001;
    ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      evaluated++;
      if ({grant, ack} !== {exp_g, exp_g}) begin
        failures++;
        $display("[TB] FAIL fair_cycle%0d: got grant=%b ack=%b expected %b", k, grant, ack, exp_g);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data[0 +: 32]  = 32'h1111_0000;
    data[32 +: 32] = 32'h2222_0001;
    req   = 4'b0011;
    ready = 1'b1;
    tick();
    tick();
    req   = 4'b0010;
    ready = 1'b0;
    #1;
    evaluated++;
    if ({grant, valid, odata} !== {4'b0010, 1'b1, 32'h2222_0001}) begin
      failures++;
      $display("[TB] FAIL mid_busy: got %h expected %h", {grant, valid, odata},
               {4'b0010, 1'b1, 32'h2222_0001});
    end
    ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    evaluated++;
    if ({grant, valid, ack, odata} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL mid_async_reset: got %h expected 0", {grant, valid, ack, odata});
    end
    #1;
    rst   = 1'b0;
    req   = 4'b0011;
    tick();
    evaluated++;
    if ({grant, ack} !== {4'b0001, 4'b0001}) begin
      failures++;
      $display("[TB] FAIL mid_pointer_reset: got grant=%b ack=%b expected 0001", grant, ack);
    end
  endtask

  task automatic test_single_requester();
    logic exp_v;
    do_reset();
    req1  = 1'b1;
    data1 = 8'h3C;
    ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_v = (k % 2 == 1);
      evaluated++;
      if ({valid1, grant1, ack1, odata1} !== {exp_v, exp_v, exp_v, exp_v ? 8'h3C : 8'h00}) begin
        failures++;
        $display("[TB] FAIL n1_cycle%0d: got valid=%b grant=%b ack=%b data=%h expected valid=%b",
                 k, valid1, grant1, ack1, odata1, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single_requester();
    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/rggen_rr_arbiter_mux.md
Name: rggen_rr_arbiter_mux

Overview:
- Round-robin arbiter and one-hot AND-OR data mux that shares one downstream channel among REQUESTERS upstream sources.
- Registers a one-hot grant, drives the granted source's payload downstream with a valid/ready handshake, and returns a per-source acknowledge on acceptance.
- Used wherever several register or bus masters contend for a single register-block access path.

Parameters:
- REQUESTERS, 4, number of requesting sources (>=1)
- WIDTH, 32, payload width in bits

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_request  input  REQUESTERS  per-source request; bit i belongs to source i
- i_data  input  REQUESTERS*WIDTH  packed payloads; source i occupies bits [i*WIDTH +: WIDTH]
- o_grant  output  REQUESTERS  registered one-hot grant, or all-zero
- o_valid  output  1  downstream valid
- i_ready  input  1  downstream ready
- o_data  output  WIDTH  payload of the granted source
- o_ack  output  REQUESTERS  one-hot acceptance pulse to the granted source

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state IDLE; o_grant=0; o_valid=0; o_ack=0; o_data=0; last-served pointer = REQUESTERS-1, so source 0 has highest priority first.
- States:
  - IDLE: o_valid=0.
  - BUSY: o_valid=1, o_grant held stable.
- Arbitration: winner is the first set bit of the candidate vector, scanning from index (last+1) mod REQUESTERS upward with wrap-around. Pure function of the candidates and the pointer.
- IDLE -> BUSY: taken when i_request != 0; winner registered into o_grant. Latency is 1 cycle from request to o_valid.
- BUSY with i_ready=0: hold o_grant and o_valid. The pointer does not change.
- BUSY with i_ready=1 (acceptance):
  - o_ack = o_grant in the same cycle (combinational).
  - Pointer <= index of o_grant.
  - Next-cycle candidates = i_request & ~o_grant.
  - If candidates != 0: remain BUSY with the new winner loaded into o_grant. This gives back-to-back transfers with no bubble.
  - Otherwise go to IDLE.
- o_data: combinational OR over sources of ({WIDTH{o_grant[i]}} & data_i). Equals 0 when o_grant=0.
- Requester protocol:
  - A source holds i_request and its payload stable from assertion through its o_ack cycle.
  - It deasserts i_request in the following cycle if it has no further data.
  - A source re-requesting right after its ack is eligible only from IDLE or after other candidates, so it cannot starve others.
- Request withdrawn while granted: a protocol violation. The arbiter still holds grant and o_valid until i_ready; the bench flags it with an assertion.
- REQUESTERS=1: o_grant is always 0 or 1; the candidate mask makes acceptance always return to IDLE for one cycle.
- Invariants:
  - $onehot0(o_grant).
  - o_valid == |o_grant.
  - o_ack == (o_grant & {REQUESTERS{o_valid & i_ready}}).
- Reset mid-transfer: all outputs return to reset values asynchronously. The pending transfer is dropped with no o_ack. The pointer returns to REQUESTERS-1.

Test Plan:
- Reset, then i_request=4'b0100, i_data[2]=32'hA5A5_0002, i_ready=1 -> next cycle o_grant=4'b0100, o_valid=1, o_data=32'hA5A5_0002, o_ack=4'b0100; with no further requests, IDLE and o_grant=0 one cycle later.
- Reset, i_request=4'b1111 held continuously, i_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one o_ack per cycle, no idle cycles.
- i_request=4'b0011, i_ready=0 for 5 cycles, then 1 -> o_grant=4'b0001 stable for all 6 cycles, o_ack[0] only in cycle 6, then o_grant=4'b0010 the next cycle.
- Source 0 re-requests every cycle while source 3 requests (4'b1001), i_ready=1 -> grants alternate 0001,1000,0001,1000; source 3 is never skipped.
- i_rst asserted mid-BUSY with o_grant=4'b0010 -> o_grant, o_valid, o_ack, o_data go to 0 immediately, no ack; after release with i_request=4'b0011, o_grant=4'b0001 (pointer reset).
- REQUESTERS=1, WIDTH=8, i_request=1, i_data=8'h3C, i_ready=1 -> o_valid pattern 0,1,0,1; o_data=8'h3C whenever o_valid; o_ack pulses each valid cycle.
